// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding and ALU opcode constants.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SRLI = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_ORI  = 4'b1001;
    localparam logic [3:0] OP_SLLI = 4'b1100;

endpackage

// File: rtl/rr_picker.sv
// Combinational picker: first set request at or above the start index (with wrap).
// Tying the start index to zero gives fixed lowest-index priority.
module rr_picker
    import alu_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(start) + i) % N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: grant, execute, respond over valid/ready.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [4*NUM_REQ-1:0]          req_op_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [ID_WIDTH-1:0]           resp_id_o,
    output logic [DATA_WIDTH-1:0]         resp_result_o,
    output logic                          resp_zero_o,
    output logic [3:0]                    ALU_Operation_o,
    output logic [DATA_WIDTH-1:0]         A_o,
    output logic [DATA_WIDTH-1:0]         B_o,
    input  logic [DATA_WIDTH-1:0]         ALU_Result_i,
    input  logic                          Zero_i,
    output logic                          busy_o
);

    state_t                state_reg;
    logic [3:0]            op_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  zero_reg;
    logic [ID_WIDTH-1:0]   id_reg;

    logic [3:0]            op_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op_i[4*gi +: 4];
            assign a_arr[gi]  = req_a_i[DATA_WIDTH*gi +: DATA_WIDTH];
            assign b_arr[gi]  = req_b_i[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    logic [ID_WIDTH-1:0] start_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] win_idx;
    logic                win_any;

`ifdef ALU_ARB_RR_EN
    logic [ID_WIDTH-1:0] ptr_reg;
    assign start_ptr = ptr_reg;
`else
    assign start_ptr = '0;
`endif

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (req_valid_i),
        .start (start_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The accept pulse must coincide with the capture edge, so it is decoded from IDLE
    // directly; it is suppressed while reset is held so nothing is accepted and dropped.
    assign req_ready_o     = (state_reg == ST_IDLE && reset) ? grant : '0;
    assign resp_valid_o    = (state_reg == ST_RESP);
    assign busy_o          = (state_reg != ST_IDLE);
    assign resp_id_o       = id_reg;
    assign resp_result_o   = result_reg;
    assign resp_zero_o     = zero_reg;
    assign ALU_Operation_o = op_reg;
    assign A_o             = a_reg;
    assign B_o             = b_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            id_reg     <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_any) begin
                        op_reg    <= op_arr[win_idx];
                        a_reg     <= a_arr[win_idx];
                        b_reg     <= b_arr[win_idx];
                        id_reg    <= win_idx;
                        state_reg <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
                        ptr_reg   <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                ST_EXEC: begin
                    result_reg <= ALU_Result_i;
                    zero_reg   <= Zero_i;
                    state_reg  <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction scoreboard plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [4*N-1:0]  req_op = '0;
    logic [DW*N-1:0] req_a = '0;
    logic [DW*N-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [IW-1:0]   resp_id;
    logic [DW-1:0]   resp_result;
    logic            resp_zero;
    logic [3:0]      alu_op;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_op_i        (req_op),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .req_ready_o     (req_ready),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_id_o       (resp_id),
        .resp_result_o   (resp_result),
        .resp_zero_o     (resp_zero),
        .ALU_Operation_o (alu_op),
        .A_o             (alu_a),
        .B_o             (alu_b),
        .ALU_Result_i    (alu_result),
        .Zero_i          (alu_zero),
        .busy_o          (busy)
    );

    // Behavioural ALU standing in for the real instance.
    function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_ADDI: return a + b;
            OP_SUB:  return a - b;
            OP_SRLI: return a >> b[4:0];
            OP_LUI:  return b;
            OP_ORI:  return a | b;
            OP_SLLI: return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    int checks = 0;
    int passes = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int pick(logic [N-1:0] v, int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

`ifdef ALU_ARB_RR_EN
    int exp02 [4] = '{0, 2, 0, 2};
    int exp12 [3] = '{1, 2, 1};
`else
    int exp02 [4] = '{0, 0, 0, 0};
    int exp12 [3] = '{1, 1, 1};
`endif

    // Transaction-level model: one op in flight, response two cycles after grant.
    bit            chk_en = 1'b0;
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_gcyc = 0;
    int            m_ptr = 0;
    int            m_id = 0;
    logic [3:0]    m_op;
    logic [31:0]   m_a, m_b, m_res;
    logic          m_zero;
    logic [N-1:0]  last_grant = '0;
    logic [N-1:0]  one_shot = '0;
    int            grant_log[$];
    int            rid_q[$];
    logic [31:0]   rres_q[$];
    logic          rzero_q[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           exp_v;
        int           w;
        cyc++;
        last_grant = req_ready;
        if (chk_en) begin
            exp_rdy = '0;
            w = -1;
            if (reset && !m_busy) begin
                w = pick(req_valid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            exp_v = m_busy && (cyc >= m_gcyc + 2);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(exp_v));
            if (m_busy) begin
                chk("alu_op", 32'(alu_op), 32'(m_op));
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
            end
            if (exp_v && resp_valid) begin
                chk("resp_id", 32'(resp_id), 32'(m_id));
                chk("resp_result", resp_result, m_res);
                chk("resp_zero", 32'(resp_zero), 32'(m_zero));
            end
            if (!reset) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end else if (exp_rdy != '0) begin
                m_busy = 1'b1;
                m_gcyc = cyc;
                m_id   = w;
                m_op   = req_op[4*w +: 4];
                m_a    = req_a[DW*w +: DW];
                m_b    = req_b[DW*w +: DW];
                m_res  = alu_f(m_op, m_a, m_b);
                m_zero = (m_res == 32'h0);
`ifdef ALU_ARB_RR_EN
                m_ptr  = (w + 1) % N;
`endif
                grant_log.push_back(w);
            end else if (exp_v && resp_ready) begin
                m_busy = 1'b0;
                rid_q.push_back(m_id);
                rres_q.push_back(m_res);
                rzero_q.push_back(m_zero);
                $display("txn id=%0d op=%h a=%h b=%h result=%h zero=%0d", m_id, m_op, m_a, m_b, m_res, m_zero);
            end
        end
    end

    // A one-shot requester withdraws valid after seeing its accept pulse.
    always @(posedge clk) begin
        #1;
        req_valid = req_valid & ~(last_grant & one_shot);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(int k, logic [3:0] op, logic [31:0] a, logic [31:0] b, bit os);
        req_op[4*k +: 4]  = op;
        req_a[DW*k +: DW] = a;
        req_b[DW*k +: DW] = b;
        one_shot[k]       = os;
        req_valid[k]      = 1'b1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rid_q.delete();
        rres_q.delete();
        rzero_q.delete();
    endtask

    task automatic wait_resp(int n);
        int b = 0;
        while (rres_q.size() < n && b < 60) begin
            step();
            b++;
        end
        if (rres_q.size() < n) chk("resp_timeout", rres_q.size(), n);
    endtask

    task automatic pop_resp(string nm, int id, logic [31:0] res, logic z);
        if (rres_q.size() == 0) begin
            chk({nm, "_present"}, 0, 1);
        end else begin
            chk({nm, "_id"}, rid_q.pop_front(), id);
            chk({nm, "_result"}, rres_q.pop_front(), res);
            chk({nm, "_zero"}, 32'(rzero_q.pop_front()), 32'(z));
        end
    endtask

    task automatic run_grants(int n);
        int b = 0;
        while (grant_log.size() < n && b < 100) begin
            step();
            b++;
        end
        if (grant_log.size() < n) chk("grant_timeout", grant_log.size(), n);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy && b < 30) begin
            step();
            b++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_result", resp_result, 0);
        chk("rst_zero", 32'(resp_zero), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_busy", 32'(busy), 0);
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        step();

        // Single ADDI on requester 0: accept at T, response at T+2.
        clear_logs();
        set_req(0, OP_ADDI, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("t1_exec_valid", 32'(resp_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(resp_valid), 1);
        chk("t1_result", resp_result, 32'd12);
        chk("t1_zero", 32'(resp_zero), 0);
        chk("t1_id", 32'(resp_id), 0);
        step();
        wait_idle();

        clear_logs();
        set_req(1, OP_ORI, 32'h0, 32'h0, 1'b1);
        wait_resp(1);
        pop_resp("ori", 1, 32'h0, 1'b1);

        clear_logs();
        set_req(3, OP_SLLI, 32'h1, 32'd31, 1'b1);
        wait_resp(1);
        pop_resp("slli", 3, 32'h80000000, 1'b0);

        clear_logs();
        set_req(2, OP_SUB, 32'd3, 32'd5, 1'b1);
        wait_resp(1);
        pop_resp("sub", 2, 32'hFFFFFFFE, 1'b0);
        wait_idle();

        // Requesters 0 and 2 held valid.
        clear_logs();
        set_req(0, OP_ADDI, 32'd10, 32'd1, 1'b0);
        set_req(2, OP_SRLI, 32'h100, 32'd4, 1'b0);
        run_grants(4);
        req_valid = '0;
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) chk($sformatf("order02_%0d", i), grant_log[i], exp02[i]);
        wait_idle();

        // Requesters 1 and 2 held valid.
        clear_logs();
        set_req(1, OP_LUI, 32'h0, 32'hABCD0000, 1'b0);
        set_req(2, OP_ORI, 32'h3, 32'h4, 1'b0);
        run_grants(3);
        req_valid = '0;
        for (int i = 0; i < 3; i++)
            if (i < grant_log.size()) chk($sformatf("order12_%0d", i), grant_log[i], exp12[i]);
        wait_idle();

        // Only requester 3 valid: granted repeatedly.
        clear_logs();
        set_req(3, OP_ADDI, 32'd1, 32'd1, 1'b0);
        run_grants(2);
        req_valid = '0;
        for (int i = 0; i < 2; i++)
            if (i < grant_log.size()) chk($sformatf("only3_%0d", i), grant_log[i], 3);
        wait_idle();

        // Backpressure: response held 5 cycles while requester 1 waits.
        clear_logs();
        resp_ready = 1'b0;
        set_req(0, OP_ADDI, 32'd1, 32'd2, 1'b1);
        set_req(1, OP_SUB, 32'd9, 32'd4, 1'b1);
        @(negedge clk);
        chk("bp_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), 32'(resp_valid), 1);
            chk($sformatf("bp_result_%0d", i), resp_result, 32'd3);
            chk($sformatf("bp_id_%0d", i), 32'(resp_id), 0);
            chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 0);
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("bp_grant1", 32'(req_ready), 32'h2);
        step();
        wait_resp(2);
        pop_resp("bp0", 0, 32'd3, 1'b0);
        pop_resp("bp1", 1, 32'd5, 1'b0);
        wait_idle();

        // Reset during EXEC drops the operation and returns the pointer to 0.
        clear_logs();
        set_req(2, OP_ADDI, 32'd7, 32'd8, 1'b1);
        @(negedge clk);
        chk("rx_grant2", 32'(req_ready), 32'h4);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rx_valid", 32'(resp_valid), 0);
        chk("rx_busy", 32'(busy), 0);
        chk("rx_result", resp_result, 0);
        chk("rx_id", 32'(resp_id), 0);
        chk("rx_a", alu_a, 0);
        chk("rx_op", 32'(alu_op), 0);
        chk("rx_ready", 32'(req_ready), 0);
        step();
        reset = 1'b1;
        set_req(1, OP_LUI, 32'h0, 32'h12345000, 1'b1);
        set_req(3, OP_ORI, 32'hF0, 32'h0F, 1'b1);
        @(negedge clk);
        chk("rx_grant1", 32'(req_ready), 32'h2);
        step();
        wait_resp(2);
        pop_resp("rx1", 1, 32'h12345000, 1'b0);
        pop_resp("rx3", 3, 32'hFF, 1'b0);
        wait_idle();

        repeat (3) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
